// File: rtl/snn_pkg.sv
// Shared constants, sweep FSM states and saturating arithmetic
// for the time-multiplexed LIF neuron array.
package snn_pkg;

  localparam int unsigned DEF_DATA_LENGTH = 32;
  localparam int unsigned DEF_BUF_SHIFT   = 5;
  localparam int unsigned DEF_LEAK_SHIFT  = 10;
  localparam int unsigned DEF_THR_SHIFT   = 10;
  localparam int unsigned DEF_REF_STEPS   = 500;

  localparam logic [31:0] DEF_V_REST  = 32'd644245094;
  localparam logic [31:0] DEF_V_RESET = 32'd214748364;
  localparam logic [31:0] DEF_THR_MIN = 32'd3650722201;
  localparam logic [31:0] DEF_THR_MAX = 32'd4080218931;
  localparam logic [31:0] DEF_THR_INC = 32'd128849018;

  localparam int unsigned SAT_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DONE
  } state_e;

  // One-bit-wider add, clamped to the all-ones value of a w-bit word.
  function automatic logic [SAT_W-1:0] sat_add(
    input logic [SAT_W-1:0] a,
    input logic [SAT_W-1:0] b,
    input int unsigned      w
  );
    logic [SAT_W:0] sum;
    logic [SAT_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ({{SAT_W{1'b0}}, 1'b1} << w) - 1'b1;
    return (sum > lim) ? lim[SAT_W-1:0] : sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/snn_neuron_array_if.sv
// Time-step handshake and spike bus between the synapse stage,
// the neuron array and the spike router.
interface snn_neuron_array_if #(
  parameter int unsigned N_NEURONS   = 8,
  parameter int unsigned DATA_LENGTH = 32
);

  logic                             step_valid;
  logic                             step_ready;
  logic [N_NEURONS*DATA_LENGTH-1:0] spike_in;
  logic [N_NEURONS-1:0]             spike_vec;
  logic                             step_done;

  modport master (
    output step_valid,
    output spike_in,
    input  step_ready,
    input  spike_vec,
    input  step_done
  );

  modport slave (
    input  step_valid,
    input  spike_in,
    output step_ready,
    output spike_vec,
    output step_done
  );

endinterface

// File: rtl/snn_neuron_update.sv
// Combinational next-state datapath for one LIF neuron:
// buffered input drain, leak, adaptive threshold, refractory.
module snn_neuron_update
  import snn_pkg::*;
#(
  parameter int unsigned DATA_LENGTH = DEF_DATA_LENGTH,
  parameter int unsigned BUF_SHIFT   = DEF_BUF_SHIFT,
  parameter int unsigned LEAK_SHIFT  = DEF_LEAK_SHIFT,
  parameter int unsigned THR_SHIFT   = DEF_THR_SHIFT,
  parameter logic [DATA_LENGTH-1:0] V_REST  = DATA_LENGTH'(DEF_V_REST),
  parameter logic [DATA_LENGTH-1:0] V_RESET = DATA_LENGTH'(DEF_V_RESET),
  parameter logic [DATA_LENGTH-1:0] THR_MIN = DATA_LENGTH'(DEF_THR_MIN),
  parameter logic [DATA_LENGTH-1:0] THR_MAX = DATA_LENGTH'(DEF_THR_MAX),
  parameter logic [DATA_LENGTH-1:0] THR_INC = DATA_LENGTH'(DEF_THR_INC),
  parameter int unsigned REF_STEPS   = DEF_REF_STEPS,
  localparam int unsigned REF_W      = $clog2(REF_STEPS + 1)
) (
  input  logic [DATA_LENGTH-1:0] i_v,
  input  logic [DATA_LENGTH-1:0] i_thr,
  input  logic [DATA_LENGTH-1:0] i_buf,
  input  logic [DATA_LENGTH-1:0] i_in,
  input  logic [REF_W-1:0]       i_ref,
  output logic [DATA_LENGTH-1:0] o_v,
  output logic [DATA_LENGTH-1:0] o_thr,
  output logic [DATA_LENGTH-1:0] o_buf,
  output logic [REF_W-1:0]       o_ref,
  output logic                   o_fire
);

  logic [DATA_LENGTH-1:0] contrib;
  logic [DATA_LENGTH-1:0] v_leak;
  logic [DATA_LENGTH-1:0] v_new;
  logic [DATA_LENGTH:0]   thr_inc;
  logic                   fire;

  always_comb begin
    contrib = '0;
    o_buf   = '0;
    o_ref   = i_ref;
    if (i_ref != '0) begin
      o_ref = i_ref - 1'b1;
    end else begin
      contrib = i_buf >> BUF_SHIFT;
      o_buf   = DATA_LENGTH'(sat_add(SAT_W'(i_buf - contrib),
                                     SAT_W'(i_in), DATA_LENGTH));
    end

    if (i_v > V_REST)
      v_leak = i_v - ((i_v - V_REST) >> LEAK_SHIFT);
    else
      v_leak = i_v + ((V_REST - i_v) >> LEAK_SHIFT);

    v_new   = DATA_LENGTH'(sat_add(SAT_W'(v_leak),
                                   SAT_W'(contrib), DATA_LENGTH));
    thr_inc = {1'b0, i_thr} + {1'b0, THR_INC};
    fire    = (v_new >= i_thr);

    o_v   = v_new;
    o_thr = i_thr - ((i_thr - THR_MIN) >> THR_SHIFT);
    if (fire) begin
      o_v   = V_RESET;
      o_ref = REF_W'(REF_STEPS);
      o_buf = '0;
      o_thr = (thr_inc > {1'b0, THR_MAX}) ? THR_MAX
                                          : thr_inc[DATA_LENGTH-1:0];
    end
  end

  assign o_fire = fire;

endmodule

// File: rtl/snn_neuron_array.sv
// Array of LIF neurons swept one per clock through a single
// shared update datapath, once per accepted time step.
module snn_neuron_array
  import snn_pkg::*;
#(
  parameter int unsigned N_NEURONS   = 8,
  parameter int unsigned DATA_LENGTH = DEF_DATA_LENGTH,
  parameter int unsigned BUF_SHIFT   = DEF_BUF_SHIFT,
  parameter int unsigned LEAK_SHIFT  = DEF_LEAK_SHIFT,
  parameter int unsigned THR_SHIFT   = DEF_THR_SHIFT,
  parameter logic [DATA_LENGTH-1:0] V_REST  = DATA_LENGTH'(DEF_V_REST),
  parameter logic [DATA_LENGTH-1:0] V_RESET = DATA_LENGTH'(DEF_V_RESET),
  parameter logic [DATA_LENGTH-1:0] THR_MIN = DATA_LENGTH'(DEF_THR_MIN),
  parameter logic [DATA_LENGTH-1:0] THR_MAX = DATA_LENGTH'(DEF_THR_MAX),
  parameter logic [DATA_LENGTH-1:0] THR_INC = DATA_LENGTH'(DEF_THR_INC),
  parameter int unsigned REF_STEPS   = DEF_REF_STEPS,
  localparam int unsigned IDX_W      = $clog2(N_NEURONS),
  localparam int unsigned REF_W      = $clog2(REF_STEPS + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  snn_neuron_array_if.slave      bus,
  input  logic [IDX_W-1:0]       i_mon_idx,
  output logic [DATA_LENGTH-1:0] o_mon_vol,
  output logic [DATA_LENGTH-1:0] o_mon_thr
);

  state_e state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_NEURONS-1:0] acc_q, acc_d;
  logic [N_NEURONS-1:0] spk_q, spk_d;
  logic                 done_q, done_d;
  logic [N_NEURONS*DATA_LENGTH-1:0] in_q, in_d;

  logic [DATA_LENGTH-1:0] vol_q [N_NEURONS];
  logic [DATA_LENGTH-1:0] vol_d [N_NEURONS];
  logic [DATA_LENGTH-1:0] thr_q [N_NEURONS];
  logic [DATA_LENGTH-1:0] thr_d [N_NEURONS];
  logic [DATA_LENGTH-1:0] ib_q  [N_NEURONS];
  logic [DATA_LENGTH-1:0] ib_d  [N_NEURONS];
  logic [REF_W-1:0]       rfc_q [N_NEURONS];
  logic [REF_W-1:0]       rfc_d [N_NEURONS];

  logic [DATA_LENGTH-1:0] cur_in;
  logic [DATA_LENGTH-1:0] u_v, u_thr, u_buf;
  logic [REF_W-1:0]       u_ref;
  logic                   u_fire;

  assign cur_in = in_q[idx_q*DATA_LENGTH +: DATA_LENGTH];

  snn_neuron_update #(
    .DATA_LENGTH (DATA_LENGTH),
    .BUF_SHIFT   (BUF_SHIFT),
    .LEAK_SHIFT  (LEAK_SHIFT),
    .THR_SHIFT   (THR_SHIFT),
    .V_REST      (V_REST),
    .V_RESET     (V_RESET),
    .THR_MIN     (THR_MIN),
    .THR_MAX     (THR_MAX),
    .THR_INC     (THR_INC),
    .REF_STEPS   (REF_STEPS)
  ) u_upd (
    .i_v    (vol_q[idx_q]),
    .i_thr  (thr_q[idx_q]),
    .i_buf  (ib_q[idx_q]),
    .i_in   (cur_in),
    .i_ref  (rfc_q[idx_q]),
    .o_v    (u_v),
    .o_thr  (u_thr),
    .o_buf  (u_buf),
    .o_ref  (u_ref),
    .o_fire (u_fire)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      spk_q   <= '0;
      done_q  <= 1'b0;
      in_q    <= '0;
      for (int k = 0; k < N_NEURONS; k++) begin
        vol_q[k] <= V_REST;
        thr_q[k] <= THR_MIN;
        ib_q[k]  <= '0;
        rfc_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      spk_q   <= spk_d;
      done_q  <= done_d;
      in_q    <= in_d;
      for (int k = 0; k < N_NEURONS; k++) begin
        vol_q[k] <= vol_d[k];
        thr_q[k] <= thr_d[k];
        ib_q[k]  <= ib_d[k];
        rfc_q[k] <= rfc_d[k];
      end
    end
  end

  // The spike vector and done pulse are loaded together on the
  // final sweep edge so both are visible during the DONE cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    spk_d   = spk_q;
    done_d  = 1'b0;
    in_d    = in_q;
    vol_d   = vol_q;
    thr_d   = thr_q;
    ib_d    = ib_q;
    rfc_d   = rfc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.step_valid) begin
          in_d    = bus.spike_in;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        vol_d[idx_q] = u_v;
        thr_d[idx_q] = u_thr;
        ib_d[idx_q]  = u_buf;
        rfc_d[idx_q] = u_ref;
        acc_d[idx_q] = u_fire;
        if (idx_q == IDX_W'(N_NEURONS - 1)) begin
          state_d = ST_DONE;
          spk_d   = acc_d;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.step_ready = (state_q == ST_IDLE);
  assign bus.spike_vec  = spk_q;
  assign bus.step_done  = done_q;

  always_comb begin
    o_mon_vol = '0;
    o_mon_thr = '0;
    if (32'(i_mon_idx) < N_NEURONS) begin
      o_mon_vol = vol_q[i_mon_idx];
      o_mon_thr = thr_q[i_mon_idx];
    end
  end

endmodule

// File: doc/snn_neuron_array.md
Name: snn_neuron_array

Overview:
- Time-multiplexed array of N leaky integrate-and-fire neurons with gradual input accumulation, exponential leak, adaptive threshold and per-neuron absolute refractory period.
- One shared update datapath sweeps all neurons, one neuron per clock, per accepted time step. Per-neuron state is held in register arrays.
- Sits between the synapse/input-weighting stage, which supplies one contribution per neuron, and the spike router, which consumes the spike vector.
- Replaces single-neuron instances when a layer needs many neurons.

Parameters:
- N_NEURONS, 8, number of neurons in the array (≥2).
- DATA_LENGTH, 32, width of all voltage, buffer and input words (unsigned).
- BUF_SHIFT, 5, input-buffer drain: contribution = buf >> BUF_SHIFT.
- LEAK_SHIFT, 10, leak toward V_REST by |v−V_REST| >> LEAK_SHIFT.
- THR_SHIFT, 10, threshold decay toward THR_MIN by (thr−THR_MIN) >> THR_SHIFT.
- V_REST, 644245094, resting voltage (0.15·2^32).
- V_RESET, 214748364, post-spike voltage (0.05·2^32).
- THR_MIN, 3650722201, threshold floor and reset value (0.85·2^32).
- THR_MAX, 4080218931, threshold ceiling (0.95·2^32).
- THR_INC, 128849018, threshold increment per spike (0.03·2^32).
- REF_STEPS, 500, refractory length in time steps (≥1).

Ports:
- i_clk, in, 1, clock.
- i_rst, in, 1, reset. Synchronous, active-high; clock is i_clk.
- i_step_valid, in, 1, time-step request.
- o_step_ready, out, 1, high when IDLE; a step is accepted when valid & ready.
- i_spike_in, in, N_NEURONS·DATA_LENGTH, per-neuron input contribution. Neuron k occupies bits [k·DATA_LENGTH +: DATA_LENGTH].
- o_spike_vec, out, N_NEURONS, spike result of the last completed step.
- o_step_done, out, 1, one-cycle pulse when o_spike_vec updates.
- i_mon_idx, in, clog2(N_NEURONS), monitor neuron select.
- o_mon_vol, out, DATA_LENGTH, combinational read of the selected neuron's v.
- o_mon_thr, out, DATA_LENGTH, combinational read of the selected neuron's thr.

Behaviour:
- Reset values:
  - All v = V_REST, thr = THR_MIN, buf = 0, ref = 0.
  - o_spike_vec = 0, o_step_done = 0, state IDLE (o_step_ready = 1).
- FSM:
  - IDLE: on valid & ready, latch i_spike_in into an input register, clear the spike accumulator, idx = 0, go to SWEEP.
  - SWEEP: update neuron idx each cycle. After idx = N_NEURONS−1, go to DONE.
  - DONE: o_spike_vec <= accumulator, o_step_done = 1 for this cycle, go to IDLE.
  - Latency: acceptance edge to o_step_done is N_NEURONS+1 cycles. o_step_ready is low throughout SWEEP and DONE; i_step_valid is ignored there, and i_spike_in changes after acceptance have no effect.
- Per-neuron update, computed from old values:
  - If ref ≠ 0: ref <= ref−1, buf <= 0, contrib = 0.
  - Else: contrib = buf >> BUF_SHIFT, buf <= sat(buf + in − contrib).
  - v_leak = v − ((v−V_REST) >> LEAK_SHIFT) if v > V_REST, else v + ((V_REST−v) >> LEAK_SHIFT).
  - v_new = sat(v_leak + contrib).
  - Fire if v_new ≥ thr:
    - spike bit idx = 1, v <= V_RESET, ref <= REF_STEPS, buf <= 0.
    - thr <= min(thr + THR_INC, THR_MAX), with the add computed one bit wider.
  - No fire:
    - v <= v_new.
    - thr <= thr − ((thr−THR_MIN) >> THR_SHIFT); a thr already at THR_MIN stays at THR_MIN.
- Arithmetic:
  - All sums are computed in DATA_LENGTH+1 bits and saturate at 2^DATA_LENGTH−1.
  - Subtractions never underflow by construction.
- Boundaries:
  - i_rst mid-sweep restores all reset values on the next edge. No o_step_done is produced for the aborted step.
  - i_step_valid held high continuously gives back-to-back steps every N_NEURONS+2 cycles.
  - i_mon_idx ≥ N_NEURONS reads 0.

Decomposition:
- Package snn_pkg:
  - Default voltage constants (V_REST, V_RESET, THR_MIN/MAX/INC).
  - Shift defaults.
  - FSM state enum {IDLE, SWEEP, DONE}.
  - Saturating-add function.
- Sub-module snn_neuron_update: purely combinational next-state datapath for one neuron, instantiated once. The array, FSM and handshake stay in the top module.

Test Plan:
- Reset, then inputs all 0 for 10 steps → o_spike_vec = 0 every step; o_mon_vol = 644245094 and o_mon_thr = 3650722201 for every idx.
- Handshake: assert valid at cycle t → o_step_ready low t+1..t+9; o_step_done pulses exactly at t+9 (N=8); valid during busy is ignored.
- Neuron 3 input 32'hFFFFFFFF every step, others 0:
  - Step 2: o_mon_vol(3) = 778462821.
  - o_spike_vec[3] rises within 40 steps; the other bits stay 0.
  - After the spike, o_mon_vol(3) = 214748364 and o_mon_thr(3) = 3779571219.
- REF_STEPS = 4, neuron 3 input held at 32'hFFFFFFFF: after a spike, the next 4 steps give no spike and o_mon_vol(3) only leaks toward V_REST; accumulation resumes at step 5.
- Repeated forced spikes → o_mon_thr clamps at 4080218931 and never exceeds it. Once input stops, thr decays monotonically and does not go below 3650722201.
- Assert i_rst at sweep cycle 3 → next cycle o_step_ready = 1, all monitored states at reset values, no o_step_done pulse.
